// File: rtl/seq_gen_pkg.sv
// seq_gen_pkg: shared types and constants for the seq_gen pattern transmitter.
//   seq_gen_state_t : FSM state encoding (PAR is only reached in parity builds)
//   SEQ_PAT_DEFAULT : default transmitted pattern (5'b10101)
package seq_gen_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      PAR  = 2'd2,
      GAP  = 2'd3
   } seq_gen_state_t;

   localparam logic [4:0] SEQ_PAT_DEFAULT = 5'b10101;

endpackage

// File: rtl/seq_gen_shreg.sv
// seq_gen_shreg: loadable PAT_W-bit parallel-in / serial-out shift register.
// Ports:
//   CLK, RST_N : clock, asynchronous active-low reset
//   load       : capture din (has priority over shift)
//   shift      : shift one place towards the MSB, zero-filling the LSB
//   din        : parallel load word
//   msb        : current serial bit (register MSB)
//   parity     : even parity of the load word, combinational
module seq_gen_shreg #(
   parameter int PAT_W = 5
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             load,
   input  logic             shift,
   input  logic [PAT_W-1:0] din,
   output logic             msb,
   output logic             parity
);

   logic [PAT_W-1:0] sreg_q;
   logic [PAT_W-1:0] sreg_d;

   function automatic logic even_parity(input logic [PAT_W-1:0] w);
      return ^w;
   endfunction

   // Next-value selection: load wins so a reload can coincide with the last shift.
   always_comb begin
      sreg_d = sreg_q;
      if (load) begin
         sreg_d = din;
      end else if (shift) begin
         sreg_d = {sreg_q[PAT_W-2:0], 1'b0};
      end else begin
         sreg_d = sreg_q;
      end
   end

   // Shift register state.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         sreg_q <= '0;
      end else begin
         sreg_q <= sreg_d;
      end
   end

   assign msb    = sreg_q[PAT_W-1];
   assign parity = even_parity(din);

endmodule

// File: rtl/seq_gen.sv
// seq_gen: serial pattern transmitter with start/busy/done handshake,
// programmable repetition count and zero-filled gap between repetitions.
// Optional feature macro: SEQ_GEN_PARITY_EN (appends an even-parity bit
// after every repetition).
// Ports:
//   CLK, RST_N : clock, asynchronous active-low reset
//   start      : burst request, accepted only while idle and not busy
//   rep_cnt    : repetitions per burst (0 behaves as 1), latched on accept
//   gap_len    : zero cycles between repetitions, latched on accept
//   code       : registered serial output, MSB of the pattern first
//   busy       : registered, high while burst bits are on code
//   done       : registered one-cycle completion pulse
module seq_gen
   import seq_gen_pkg::*;
#(
   parameter int               PAT_W   = 5,
   parameter logic [PAT_W-1:0] PATTERN = PAT_W'(SEQ_PAT_DEFAULT),
   parameter int               REP_W   = 4,
   parameter int               GAP_W   = 4
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             start,
   input  logic [REP_W-1:0] rep_cnt,
   input  logic [GAP_W-1:0] gap_len,
   output logic             code,
   output logic             busy,
   output logic             done
);

   localparam int               IDX_W   = $clog2(PAT_W);
   localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(PAT_W - 1);

   seq_gen_state_t   state_q, state_d;
   logic [REP_W-1:0] rep_q, rep_d;
   logic [GAP_W-1:0] gap_q, gap_d;
   logic [GAP_W-1:0] gcnt_q, gcnt_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             code_q, code_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic             load_s;
   logic             shift_s;
   logic             rep_end_s;
   logic             msb_s;
   logic             par_s;

   seq_gen_shreg #(
      .PAT_W (PAT_W)
   ) u_shreg (
      .CLK    (CLK),
      .RST_N  (RST_N),
      .load   (load_s),
      .shift  (shift_s),
      .din    (PATTERN),
      .msb    (msb_s),
      .parity (par_s)
   );

`ifndef SEQ_GEN_PARITY_EN
   logic unused_par_s;
   assign unused_par_s = par_s;
`endif

   // Next-state, counter and output computation. The output registers lag the
   // state by one cycle, so the FSM is already IDLE while the last bit is still
   // on code; busy_q distinguishes that trailing cycle and produces done.
   always_comb begin
      state_d   = state_q;
      rep_d     = rep_q;
      gap_d     = gap_q;
      gcnt_d    = gcnt_q;
      idx_d     = idx_q;
      code_d    = 1'b0;
      busy_d    = 1'b0;
      done_d    = 1'b0;
      load_s    = 1'b0;
      shift_s   = 1'b0;
      rep_end_s = 1'b0;

      case (state_q)
         IDLE: begin
            if (busy_q) begin
               done_d = 1'b1;
            end else if (start) begin
               rep_d   = (rep_cnt == REP_W'(0)) ? REP_W'(1) : rep_cnt;
               gap_d   = gap_len;
               load_s  = 1'b1;
               idx_d   = IDX_MAX;
               state_d = SEND;
            end else begin
               state_d = IDLE;
            end
         end
         SEND: begin
            code_d  = msb_s;
            busy_d  = 1'b1;
            shift_s = 1'b1;
            if (idx_q == IDX_W'(0)) begin
`ifdef SEQ_GEN_PARITY_EN
               state_d = PAR;
`else
               rep_end_s = 1'b1;
`endif
            end else begin
               idx_d = idx_q - IDX_W'(1);
            end
         end
`ifdef SEQ_GEN_PARITY_EN
         PAR: begin
            code_d    = par_s;
            busy_d    = 1'b1;
            rep_end_s = 1'b1;
         end
`endif
         GAP: begin
            busy_d = 1'b1;
            if (gcnt_q <= GAP_W'(1)) begin
               gcnt_d  = GAP_W'(0);
               load_s  = 1'b1;
               idx_d   = IDX_MAX;
               state_d = SEND;
            end else begin
               gcnt_d = gcnt_q - GAP_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // End of one repetition: finish, insert a gap, or restart back-to-back.
      if (rep_end_s) begin
         if (rep_q <= REP_W'(1)) begin
            rep_d   = REP_W'(0);
            state_d = IDLE;
         end else if (gap_q != GAP_W'(0)) begin
            rep_d   = rep_q - REP_W'(1);
            gcnt_d  = gap_q;
            state_d = GAP;
         end else begin
            rep_d   = rep_q - REP_W'(1);
            load_s  = 1'b1;
            idx_d   = IDX_MAX;
            state_d = SEND;
         end
      end else begin
         rep_d = rep_d;
      end
   end

   // State, counters and registered outputs.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= IDLE;
         rep_q   <= '0;
         gap_q   <= '0;
         gcnt_q  <= '0;
         idx_q   <= '0;
         code_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         rep_q   <= rep_d;
         gap_q   <= gap_d;
         gcnt_q  <= gcnt_d;
         idx_q   <= idx_d;
         code_q  <= code_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign code = code_q;
   assign busy = busy_q;
   assign done = done_q;

endmodule

// File: tb/tb_seq_gen.sv
// tb_seq_gen: scoreboard bench for seq_gen. The driver pushes the expected
// {code,busy,done} of every cycle into a queue as it issues stimulus; the
// monitor pops one entry per cycle, #1 after the rising edge, and compares.
module tb_seq_gen;

   typedef struct packed {
      logic [7:0] tid;
      logic       code;
      logic       busy;
      logic       done;
   } exp_t;

   logic       CLK = 1'b0;
   logic       RST_N;
   logic       start;
   logic [3:0] rep_cnt;
   logic [3:0] gap_len;
   logic       code;
   logic       busy;
   logic       done;

   exp_t  sb_q[$];
   int    checks = 0;
   int    errors = 0;
   int    cyc    = 0;
   string s1, s2, s3, s6;

   seq_gen dut (
      .CLK     (CLK),
      .RST_N   (RST_N),
      .start   (start),
      .rep_cnt (rep_cnt),
      .gap_len (gap_len),
      .code    (code),
      .busy    (busy),
      .done    (done)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string name, input logic [2:0] act, input logic [2:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         errors = errors + 1;
         $display("FAIL %s at t=%0t: {code,busy,done} got %b expected %b", name, $time, act, exp);
      end
   endtask

   // Monitor: one scoreboard entry per clock cycle.
   always @(posedge CLK) begin
      exp_t e;
      #1;
      cyc = cyc + 1;
      if (sb_q.size() != 0) begin
         e = sb_q.pop_front();
         chk($sformatf("t%0d_cyc%0d", e.tid, cyc), {code, busy, done}, {e.code, e.busy, e.done});
      end
   end

   task automatic push(input int tid, input logic c, input logic b, input logic d);
      exp_t e;
      e.tid  = 8'(tid);
      e.code = c;
      e.busy = b;
      e.done = d;
      sb_q.push_back(e);
   endtask

   // Acceptance cycle (idle), the pattern bits, then the done cycle.
   task automatic push_burst(input int tid, input string s);
      push(tid, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < s.len(); i++) begin
         push(tid, (s[i] == 8'h31), 1'b1, 1'b0);
      end
      push(tid, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic push_idle(input int tid, input int n);
      for (int i = 0; i < n; i++) begin
         push(tid, 1'b0, 1'b0, 1'b0);
      end
   endtask

   // Called at a falling edge; returns at the middle of the acceptance cycle.
   task automatic start_burst(input int tid, input logic [3:0] r, input logic [3:0] g, input string s);
      rep_cnt = r;
      gap_len = g;
      start   = 1'b1;
      push_burst(tid, s);
      @(negedge CLK);
      start = 1'b0;
   endtask

   task automatic wait_drain(input int tid);
      int n;
      n = 0;
      while (sb_q.size() != 0 && n < 300) begin
         @(negedge CLK);
         n = n + 1;
      end
      if (sb_q.size() != 0) begin
         checks = checks + 1;
         errors = errors + 1;
         $display("FAIL t%0d_drain: %0d entries left, required 0", tid, sb_q.size());
         sb_q.delete();
      end
   endtask

   initial begin
`ifdef SEQ_GEN_PARITY_EN
      s1 = "101011";
      s2 = "101011101011";
      s3 = "101011000101011";
      s6 = "10101101010110101011";
`else
      s1 = "10101";
      s2 = "1010110101";
      s3 = "1010100010101";
      s6 = "10101010101010101";
`endif
      RST_N   = 1'b0;
      start   = 1'b0;
      rep_cnt = 4'd0;
      gap_len = 4'd0;
      repeat (2) @(negedge CLK);
      chk("reset_state", {code, busy, done}, 3'b000);
      RST_N = 1'b1;
      @(negedge CLK);

      // T1: single repetition.
      start_burst(1, 4'd1, 4'd0, s1);
      push_idle(1, 2);
      wait_drain(1);

      // T2: two back-to-back repetitions (overlap case).
      start_burst(2, 4'd2, 4'd0, s2);
      push_idle(2, 2);
      wait_drain(2);

      // T3: gap of 3; inputs change after accept and must be ignored.
      start_burst(3, 4'd2, 4'd3, s3);
      rep_cnt = 4'd1;
      gap_len = 4'd0;
      push_idle(3, 2);
      wait_drain(3);

      // T4: rep 0 acts as 1; start pulses during the burst are ignored,
      // including one sampled while the last bit is still on code.
      start_burst(4, 4'd0, 4'd3, s1);
      push_idle(4, 2);
      @(negedge CLK);
      @(negedge CLK);
      start   = 1'b1;
      rep_cnt = 4'd3;
      gap_len = 4'd0;
      @(negedge CLK);
      start = 1'b0;
      repeat (s1.len() - 3) @(negedge CLK);
      start   = 1'b1;
      rep_cnt = 4'd2;
      @(negedge CLK);
      start = 1'b0;
      wait_drain(4);

      // T5: reset asserted during cycle 3 of a rep=3 burst.
      rep_cnt = 4'd3;
      gap_len = 4'd0;
      start   = 1'b1;
      push(5, 1'b0, 1'b0, 1'b0);
      push(5, 1'b1, 1'b1, 1'b0);
      push(5, 1'b0, 1'b1, 1'b0);
      push(5, 1'b1, 1'b1, 1'b0);
      @(negedge CLK);
      start = 1'b0;
      repeat (3) @(negedge CLK);
      RST_N = 1'b0;
      #1;
      chk("abort_immediate", {code, busy, done}, 3'b000);
      push_idle(5, 2);
      @(negedge CLK);
      @(negedge CLK);
      RST_N = 1'b1;
      push_idle(5, 4);
      wait_drain(5);
      start_burst(5, 4'd1, 4'd0, s1);
      push_idle(5, 2);
      wait_drain(5);

      // T6: start during the done cycle is accepted with no dead cycle.
      start_burst(6, 4'd1, 4'd0, s1);
      repeat (s1.len() + 1) @(negedge CLK);
      start_burst(6, 4'd3, 4'd1, s6);
      push_idle(6, 2);
      wait_drain(6);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/seq_gen.md
# seq_gen

Pattern transmitter for the FPGA sequence-detection lab: it serializes a fixed bit pattern, MSB first, onto a single-bit `code` line, one bit per `CLK` cycle. It is the stimulus source for the 10101 detector. The block supports a start/busy/done handshake, a programmable repetition count, and a programmable zero-filled gap between repetitions. With gap 0, repetitions are sent back-to-back, which exercises overlapping detection.

## Interface
Parameters:
- `PAT_W`, default 5: pattern length in bits; must be ≥ 2.
- `PATTERN`, default 5'b10101: pattern to transmit; bit `PAT_W-1` goes out first.
- `REP_W`, default 4: width of the repetition count.
- `GAP_W`, default 4: width of the gap length.

Ports:
- `CLK`  in  1: the single clock; all state updates on posedge.
- `RST_N`  in  1: asynchronous, active-low reset.
- `start`  in  1: request a transmission burst; sampled on posedge while idle.
- `rep_cnt`  in  REP_W: number of pattern repetitions; 0 is treated as 1; latched on accept.
- `gap_len`  in  GAP_W: number of zero cycles between repetitions; latched on accept.
- `code`  out  1: serial output bit, registered.
- `busy`  out  1: high while a burst is in progress, registered.
- `done`  out  1: one-cycle pulse when a burst has completed, registered.

## Operation
- States: IDLE, SEND, PAR, GAP. PAR exists only when the configuration macro is defined.
- **IDLE**
  - Outputs: `code`=0, `busy`=0.
  - On `start`=1 at posedge: latch `rep_cnt` (0→1) and `gap_len`, load the shift register with `PATTERN`, set bit index to `PAT_W-1`, go to SEND.
- **SEND**
  - `code` = current pattern bit, `busy`=1, bit index decrements each cycle.
  - After bit 0:
    - With parity enabled, go to PAR.
    - Otherwise, run end-of-repetition handling.
- **PAR**
  - `code` = XOR of all `PATTERN` bits (even parity), for one cycle.
  - Then run end-of-repetition handling.
- **End of repetition**
  - Decrement the remaining repetitions.
  - If the count is now 0: go to IDLE and pulse `done`.
  - Else, if the latched `gap_len` > 0: go to GAP.
  - Else: reload the pattern and go to SEND immediately, with no idle cycle.
- **GAP**
  - `code`=0, `busy`=1, for exactly `gap_len` cycles.
  - Then reload the pattern and go to SEND.
- `start` is ignored whenever `busy`=1.
- Latched `rep_cnt` and `gap_len` are unaffected by input changes during a burst.
- Counters are unsigned. The repetition counter is REP_W bits; the gap counter is GAP_W bits; the bit index is $clog2(PAT_W) bits. No wrap-around occurs, because every counter stops at its terminal value.

## Timing
- Reset: asserting `RST_N`=0 immediately forces `code`=0, `busy`=0, `done`=0, state IDLE, and clears all counters. No `done` is produced for an aborted burst. Deassertion is expected to be synchronous to `CLK` at board level.
- Latency: with `start` accepted at edge N, the first pattern bit appears on `code` and `busy` rises after edge N+1.
- Burst length: a burst occupies R·(PAT_W + P) + (R−1)·G cycles.
  - R = effective repetition count.
  - P = 1 if parity is enabled, else 0.
  - G = latched gap length.
- Completion: the cycle after the last transmitted bit, `busy`=0, `done`=1, and `code`=0.
- `done` is high for one cycle only.
- A `start` sampled on the edge that ends the `done` cycle is accepted: the state is IDLE, so there is no dead cycle between bursts.
- Simultaneous events: the `start`/`done` overlap is resolved as above.

## Configuration
- Macro: `SEQ_GEN_PARITY_EN`.
- Defined: after each repetition, one even-parity bit is sent in state PAR, between the last pattern bit and the gap (or the next pattern).
- Undefined: the PAR state and its logic are absent, and patterns are sent without a parity bit.

## Structure
- Package `seq_gen_pkg` holds:
  - the state enum `seq_gen_state_t` (IDLE, SEND, PAR, GAP);
  - the default pattern constant `SEQ_PAT_DEFAULT = 5'b10101`.
- Sub-module `seq_gen_shreg`: a loadable PAT_W-bit parallel-in serial-out register with load and shift enables and MSB output. It also computes the parity of the loaded word combinationally.
- The top level holds the FSM, the repetition and gap counters, and the output registers.

## Test plan
- rep=1, gap=0, no parity, start at edge 0 → `code` = 1,0,1,0,1 in cycles 1–5; `busy` high in cycles 1–5; `done`=1 in cycle 6 only.
- rep=2, gap=0 → `code` = 1010110101 in cycles 1–10; a detector attached downstream fires twice (overlap case); `done` in cycle 11.
- rep=2, gap=3 → `code` = 10101 000 10101 in cycles 1–13; `busy` high throughout; `done` in cycle 14.
- rep=0 and mid-burst pulses of `start` with changing `rep_cnt`/`gap_len` → a single repetition of 10101 is sent; the later `start`s and input changes have no effect.
- Abort: `RST_N` low during cycle 3 of a rep=3 burst → `code`, `busy` and `done` are 0 at once; no `done` afterwards; a new `start` after release produces a clean 10101.
- With `SEQ_GEN_PARITY_EN`, rep=2, gap=1 → `code` = 101011 0 101011; `done` in cycle 14.
